// File: rtl/riscv_isa_pkg.sv
// riscv_isa_pkg: shared RV32I encoding definitions.
//   - Major opcode constants used to pick an instruction format.
//   - fmt_t: instruction format enum driving field packing and immediate checks.
//   - Shift funct3 values that turn an OP_IMM instruction into a shift.
//   - fmt_of(): maps (opcode, funct3) to a format.
package riscv_isa_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_t;

    // Any opcode not listed here is packed as R-type.
    function automatic fmt_t fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
        fmt_t f;
        case (opcode)
            LOAD, JALR:   f = FMT_I;
            OP_IMM:       f = (funct3 == F3_SLL || funct3 == F3_SRL_SRA) ? FMT_SH : FMT_I;
            STORE:        f = FMT_S;
            BRANCH:       f = FMT_B;
            LUI, AUIPC:   f = FMT_U;
            JAL:          f = FMT_J;
            default:      f = FMT_R;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// imm_range_check: decides whether a full byte-offset immediate fits the
// immediate field of the given instruction format.
//   fmt   (in)  : instruction format
//   imm   (in)  : 32-bit immediate as the decoder would produce it
//   legal (out) : 1 when the immediate encodes without loss
module imm_range_check
    import riscv_isa_pkg::*;
(
    input  fmt_t        fmt,
    input  logic [31:0] imm,
    output logic        legal
);

    // "All equal" upper bits means the value is a correct sign extension of
    // the field's top bit, so replicating that bit is the reference pattern.
    always_comb begin
        legal = 1'b1;
        case (fmt)
            FMT_I, FMT_S: legal = (imm[31:11] == {21{imm[11]}});
            FMT_SH:       legal = (imm[31:5] == 27'd0);
            FMT_B:        legal = (imm[31:12] == {20{imm[12]}}) && !imm[0];
            FMT_J:        legal = (imm[31:20] == {12{imm[20]}}) && !imm[0];
            FMT_U:        legal = (imm[11:0] == 12'd0);
            default:      legal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction encoder.
// Packs opcode/register/funct/immediate fields into a 32-bit instruction word
// and buffers results in a 2-entry output FIFO.
//
// Optional feature macro: INSTR_ENCODER_IMM_CHECK_EN
//   defined   : immediate legality check, err_o per word, saturating err_cnt_o
//   undefined : no checker, err_o and err_cnt_o tied to 0
//
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   valid_i / ready_o    : input handshake
//   opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i : fields to pack
//   valid_o / ready_i    : output handshake
//   instr_o              : encoded word at FIFO head
//   err_o                : head word's immediate was not encodable
//   err_cnt_o            : saturating count of accepted illegal immediates
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. ready_o is a register derived from FIFO occupancy only (never
// from ready_i). Once valid_o is high, instr_o/err_o stay stable until the
// word is taken.
module instr_encoder
    import riscv_isa_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [31:0]          imm_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [31:0]          instr_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    localparam int ENT_W = 33;
`else
    localparam int ENT_W = 32;
`endif

    fmt_t        fmt;
    logic [31:0] enc;
    logic [ENT_W-1:0] entry;

    logic [ENT_W-1:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       ready_q;
    logic       push;
    logic       pop;

    assign fmt = fmt_of(opcode_i, funct3_i);

    always_comb begin
        enc = 32'd0;
        case (fmt)
            FMT_I:  enc = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_SH: enc = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S:  enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B:  enc = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], opcode_i};
            FMT_U:  enc = {imm_i[31:12], rd_i, opcode_i};
            FMT_J:  enc = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: enc = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        endcase
    end

    assign push = valid_i && ready_q;
    assign pop  = valid_o && ready_i;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    logic                 legal;
    logic [ERR_CNT_W-1:0] err_cnt;

    imm_range_check u_imm_range_check (
        .fmt   (fmt),
        .imm   (imm_i),
        .legal (legal)
    );

    // Illegal immediates are still emitted (truncated); the flag rides along.
    assign entry = {~legal, enc};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if (push && !legal && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign err_cnt_o = err_cnt;
    assign err_o     = mem[rd_ptr][32];
`else
    assign entry     = enc;
    assign err_cnt_o = '0;
    assign err_o     = 1'b0;
`endif

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // Storage is cleared on reset so instr_o reads 0 until the first push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_nxt;
            ready_q <= (count_nxt != 2'd2);
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (count != 2'd0);
    assign instr_o = mem[rd_ptr][31:0];

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized stimulus for instr_encoder,
// checked against a reference model that encodes from field tables with
// plain arithmetic and judges immediates by numeric range.
module tb_instr_encoder;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int ECW = 4;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           valid_i;
    logic           ready_o;
    logic [6:0]     opcode_i;
    logic [2:0]     funct3_i;
    logic [6:0]     funct7_i;
    logic [4:0]     rd_i;
    logic [4:0]     rs1_i;
    logic [4:0]     rs2_i;
    logic [31:0]    imm_i;
    logic           valid_o;
    logic           ready_i;
    logic [31:0]    instr_o;
    logic           err_o;
    logic [ECW-1:0] err_cnt_o;

    instr_encoder #(.ERR_CNT_W(ECW)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .opcode_i  (opcode_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .rd_i      (rd_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .imm_i     (imm_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .instr_o   (instr_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    logic [32:0] exp_q[$];   // {err, instr} expected from the model
    logic [33:0] gold_q[$];  // {has_gold, err, instr} from hand-computed values
    int          ecnt = 0;
    bit          accepted;
    bit          g_has;
    logic [32:0] g_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: numbers in, shifted/masked fields out.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
        logic [31:0] o, r1, r2, d, f3w, f7w, e;
        longint sv;
        bit bad;
        o   = 32'(op);
        r1  = 32'(rs1) << 15;
        r2  = 32'(rs2) << 20;
        d   = 32'(rd) << 7;
        f3w = 32'(f3) << 12;
        f7w = 32'(f7) << 25;
        sv  = longint'($signed(imm));
        bad = 1'b0;
        if ((op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))) begin
            e   = f7w | ((imm & 32'h1F) << 20) | r1 | f3w | d | o;
            bad = (imm > 32'd31);
        end else if (op == 7'h03 || op == 7'h67 || op == 7'h13) begin
            e   = ((imm & 32'hFFF) << 20) | r1 | f3w | d | o;
            bad = (sv < -2048) || (sv > 2047);
        end else if (op == 7'h23) begin
            e   = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | f3w | ((imm & 32'h1F) << 7) | o;
            bad = (sv < -2048) || (sv > 2047);
        end else if (op == 7'h63) begin
            e   = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2 | r1 | f3w
                | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
            bad = (sv < -4096) || (sv > 4095) || (imm % 2 != 0);
        end else if (op == 7'h37 || op == 7'h17) begin
            e   = (imm & 32'hFFFFF000) | d | o;
            bad = (imm % 4096 != 0);
        end else if (op == 7'h6F) begin
            e   = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
            bad = (sv < -1048576) || (sv > 1048575) || (imm % 2 != 0);
        end else begin
            e   = f7w | r2 | r1 | f3w | d | o;
            bad = 1'b0;
        end
        return {bad & CHK, e};
    endfunction

    // One clock: check at the negedge, account for transfers, advance past posedge.
    task automatic cycle();
        logic [32:0] h;
        logic [33:0] g;
        bit mready;
        @(negedge clk);
        mready = (exp_q.size() < 2);
        check("valid_o", 32'(valid_o), 32'(exp_q.size() != 0));
        check("ready_o", 32'(ready_o), 32'(mready));
        check("err_cnt_o", 32'(err_cnt_o), 32'(ecnt));
        if (exp_q.size() != 0 && ready_i) begin
            h = exp_q.pop_front();
            g = gold_q.pop_front();
            check("instr_o", instr_o, h[31:0]);
            check("err_o", 32'(err_o), 32'(h[32]));
            if (g[33]) begin
                check("instr_gold", instr_o, g[31:0]);
                check("err_gold", 32'(err_o), 32'(g[32]));
            end
        end
        accepted = valid_i && mready;
        if (accepted) begin
            h = model(opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i);
            exp_q.push_back(h);
            gold_q.push_back({g_has, g_word});
            if (h[32] && ecnt < (1 << ECW) - 1) ecnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_item(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input bit has, input bit gerr,
                            input logic [31:0] gword);
        opcode_i = op; funct3_i = f3; funct7_i = f7;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        g_has = has; g_word = {gerr, gword};
        valid_i = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            cycle();
            n++;
        end
        check("accept_timeout", 32'(accepted), 32'd1);
        valid_i = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input bit gerr, input logic [31:0] gword);
        set_item(op, f3, f7, rd, rs1, rs2, imm, 1'b1, gerr, gword);
        wait_accept();
    endtask

    task automatic rand_item();
        logic [6:0] ops [10];
        logic [6:0] op;
        logic [2:0] f3;
        logic [31:0] imm;
        ops = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        op = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 9) == 0) op = 7'($urandom());
        f3 = 3'($urandom());
        case ($urandom_range(0, 5))
            0: imm = $urandom();
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm = 32'($urandom_range(0, 4095)) << 12;
            3: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
            4: imm = 32'($urandom_range(0, 63));
            default: imm = 32'($urandom_range(0, 4095));
        endcase
        set_item(op, f3, 7'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                 imm, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        opcode_i = '0; funct3_i = '0; funct7_i = '0;
        rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
        g_has = 1'b0; g_word = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_instr_o", instr_o, 32'd0);
        check("rst_err_o", 32'(err_o), 32'd0);
        check("rst_err_cnt_o", 32'(err_cnt_o), 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // addi x1,x2,-1
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF10093);
        cycle();
        cycle();

        // sw, beq, jal, lui back to back
        send(7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'd8, 1'b0, 32'h00512423);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 32'hFE000EE3);
        send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b0, 32'h001000EF);
        send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123452B7);
        cycle();

        // srai x3,x3,4
        send(7'h13, 3'd5, 7'h20, 5'd3, 5'd3, 5'd0, 32'd4, 1'b0, 32'h4041D193);
        cycle();

        // immediate legality: addi 0x800, beq 6, beq 5
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, CHK, 32'h80000093);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd6, 1'b0, 32'h00000363);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5, CHK, 32'h00000263);
        cycle();
        cycle();
        check("err_cnt_two", 32'(err_cnt_o), CHK ? 32'd2 : 32'd0);

        // backpressure: two accepted, third waits until the consumer drains
        ready_i = 1'b0;
        send(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h003100B3);
        send(7'h33, 3'd0, 7'h20, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0, 32'h40628233);
        set_item(7'h13, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd1, 1'b1, 1'b0, 32'h00100393);
        repeat (3) cycle();
        check("full_ready_low", 32'(ready_o), 32'd0);
        check("full_no_accept", 32'(accepted), 32'd0);
        ready_i = 1'b1;
        wait_accept();
        repeat (3) cycle();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // reset with two words buffered
        ready_i = 1'b0;
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1000, CHK, 32'h00000093);
        send(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd3, 1'b0, 32'h00300113);
        rst_i = 1'b1;
        cycle();
        exp_q.delete();
        gold_q.delete();
        ecnt = 0;
        rst_i = 1'b0;
        @(negedge clk);
        check("mid_rst_valid_o", 32'(valid_o), 32'd0);
        check("mid_rst_ready_o", 32'(ready_o), 32'd1);
        check("mid_rst_err_cnt_o", 32'(err_cnt_o), 32'd0);
        check("mid_rst_instr_o", instr_o, 32'd0);
        @(posedge clk); #1;

        // randomized traffic with random backpressure
        for (int k = 0; k < 1500; k++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            if (!valid_i && $urandom_range(0, 3) != 0) rand_item();
            cycle();
            if (accepted) valid_i = 1'b0;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) cycle();
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: packs opcode, register, funct and immediate fields into a 32-bit instruction word. It is the write-side counterpart of the core's immediate extraction path, and feeds the self-test instruction stream generator and the debug program-injection port. A valid/ready input feeds a 2-entry output buffer. Illegal (unencodable) immediates are flagged and counted.

## Interface
- `ERR_CNT_W`, default 16: width of the saturating error counter.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: synchronous active-high reset.
- `valid_i`, in, 1: input fields valid.
- `ready_o`, out, 1: encoder can accept.
- `opcode_i`, in, 7: major opcode.
- `funct3_i`, in, 3: funct3.
- `funct7_i`, in, 7: funct7; used for R-type and shifts.
- `rd_i`, in, 5: destination register.
- `rs1_i`, in, 5: source register 1.
- `rs2_i`, in, 5: source register 2.
- `imm_i`, in, 32: full byte-offset immediate, as the decoder would produce it.
- `valid_o`, out, 1: encoded word valid.
- `ready_i`, in, 1: consumer accepts.
- `instr_o`, out, 32: encoded instruction.
- `err_o`, out, 1: immediate of the current `instr_o` was not encodable.
- `err_cnt_o`, out, ERR_CNT_W: saturating count of accepted illegal immediates.

## Operation
- Format is selected from `opcode_i`:
  - 0000011, 1100111 and 0010011 use I-type.
  - 0010011 with funct3 001 or 101 is a shift. Encode {funct7_i, imm[4:0], rs1, funct3, rd, opcode}.
  - 0100011 uses S-type; 1100011 uses B-type.
  - 0110111 and 0010111 use U-type, encoded as {imm[31:12], rd, opcode}.
  - 1101111 uses J-type.
  - Any other opcode uses R-type {funct7, rs2, rs1, funct3, rd, opcode}. R-type never sets an error.
- Field packing:
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Legality rules:
  - I/S: imm[31:11] all equal.
  - Shift: imm[31:5]==0.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
- An illegal immediate is still encoded (bits truncated) and emitted. `err_o`=1 travels with that word.
- `err_cnt_o` increments on acceptance of an illegal item and saturates at all-ones.
- Output buffer:
  - 2-entry FIFO holding {instr, err}.
  - Push on `valid_i && ready_o`; pop on `valid_o && ready_i`.

## Timing
- Reset values: `valid_o`=0, `instr_o`=0, `err_o`=0, `err_cnt_o`=0, `ready_o`=1, FIFO empty. Reset mid-stream discards buffered words.
- Encoding is combinational on inputs and registered on push. Latency is 1 cycle: a word accepted in cycle N appears at `instr_o` in cycle N+1 if the FIFO was empty.
- `ready_o` = (count < 2), registered from count and independent of `ready_i`.
- Count 1 with simultaneous push and pop: count stays 1, order is preserved, and the new word is next.
- Count 2: `ready_o`=0 and no push occurs even if `ready_i`=1 this cycle. Pop frees a slot, so `ready_o`=1 next cycle.
- `instr_o`/`err_o` are held stable while `valid_o && !ready_i`.
- `err_cnt_o` updates the cycle after acceptance.

## Configuration
- Macro `INSTR_ENCODER_IMM_CHECK_EN`:
  - Defined: legality checking, `err_o` and `err_cnt_o` are implemented as above.
  - Undefined: no checker, the FIFO entry omits the err bit, `err_o` is tied 0 and `err_cnt_o` is tied 0. Encoding is otherwise identical.

## Structure
- Shared package `riscv_isa_pkg` holds:
  - the opcode constants (LOAD, STORE, JAL, LUI, JALR, AUIPC, BRANCH, OP_IMM);
  - a format enum {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J};
  - shift funct3 values 001/101.
- Sub-module `imm_range_check`:
  - inputs: format and imm; output: legal flag;
  - instantiated only under the macro.

## Test plan
1. addi x1,x2,-1 (op 0010011, f3 000, imm 0xFFFFFFFF) -> instr_o 0xFFF10093, err_o 0, one cycle after accept.
2. sw x5,8(x2), beq x0,x0,-4, jal x1,0x800 and lui x5,0x12345000 back-to-back with ready_i=1 -> 0x00512423, 0xFE000EE3, 0x001000EF, 0x123452B7 in order on consecutive cycles.
3. srai x3,x3,4 (f3 101, funct7 0100000) -> 0x4041D193.
4. addi with imm 0x800, then beq with imm 6 (misaligned is legal: 6[0]=0), then beq with imm 5 -> err_o 1, 0, 1; err_cnt_o reaches 2.
5. ready_i=0, three items offered -> two accepted, ready_o low from the cycle after the 2nd push. Raise ready_i -> words drain in order and the third is accepted.
6. rst_i asserted with 2 buffered words -> next cycle valid_o 0, ready_o 1, err_cnt_o 0.
